// File: rtl/fp_isqrt_pkg.sv
// ============================================================================
// Module      : fp_isqrt_pkg
// Description : Shared definitions for the fixed-point isqrt family.
//               FSM state encoding plus the constant helpers used to size
//               the inverse unit (dividend exponent, saturation value and
//               bit-counter width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_isqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQR  = 3'd1,
        CHK  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Exponent of the dividend N = 2^(2*WF+WFO): 2*WF cancels the fractional
    // scaling of y^2, WFO supplies the output fraction.
    function automatic int n_exp(input int wf, input int wfo);
        return 2 * wf + wfo;
    endfunction

    // Largest positive value of a WL-bit signed word.
    function automatic logic [63:0] sat_val(input int wl);
        return (64'd1 << (wl - 1)) - 64'd1;
    endfunction

    // Width of the quotient-bit counter.
    function automatic int cnt_w(input int wl);
        return $clog2(wl);
    endfunction

endpackage : fp_isqrt_pkg

`default_nettype wire

// File: rtl/fp_udiv_restoring.sv
// ============================================================================
// Module      : fp_udiv_restoring
// Description : Bit-serial restoring divider, one quotient bit per enabled
//               step, MSB first. Owns remainder, quotient and bit index.
// Ports       : clk, rst_n  - clock, async active-low reset
//               ce          - clock enable
//               load        - initialise rem=num, q=0, i=QW-1
//               step        - perform one trial subtraction at bit i
//               num, den    - dividend / divisor (held stable while stepping)
//               q_next      - quotient including the current step
//               done        - current step is the final one (i == 0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_udiv_restoring #(
    parameter int DW = 40,
    parameter int QW = 19,
    parameter int CW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               load,
    input  logic               step,
    input  logic [DW+QW-1:0]   num,
    input  logic [DW-1:0]      den,
    output logic [QW-1:0]      q_next,
    output logic               done
);

    localparam int RW = DW + QW;

    logic [RW-1:0] rem_q, rem_d;
    logic [QW-1:0] q_q, q_d;
    logic [CW-1:0] i_q, i_d;
    logic [RW-1:0] trial;

    always_comb begin
        rem_d = rem_q;
        q_d   = q_q;
        i_d   = i_q;
        trial = {{QW{1'b0}}, den} << i_q;
        if (load) begin
            rem_d = num;
            q_d   = '0;
            i_d   = CW'(QW - 1);
        end else if (step) begin
            if (rem_q >= trial) begin
                rem_d    = rem_q - trial;
                q_d[i_q] = 1'b1;
            end
            // Wraps after bit 0; the owner stops stepping at that point.
            i_d = i_q - 1'b1;
        end
    end

    assign q_next = q_d;
    assign done   = (i_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            q_q   <= '0;
            i_q   <= '0;
        end else if (ce) begin
            rem_q <= rem_d;
            q_q   <= q_d;
            i_q   <= i_d;
        end
    end

endmodule : fp_udiv_restoring

`default_nettype wire

// File: rtl/fp_sisqrt_inv.sv
// ============================================================================
// Module      : fp_sisqrt_inv
// Description : Inverse of the reciprocal-square-root unit: x = 1/y^2 in
//               fixed point. Square, range check, then restoring division.
// Ports       : CLK, nRST  - clock, async active-low reset
//               CE         - clock enable (everything holds when low)
//               start, din - request and signed Q(WI.WF) operand y
//               busy       - operation in flight
//               valid      - one-cycle result strobe
//               dout, ovf  - Q(WIO.WFO) result and saturation flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_sisqrt_inv
    import fp_isqrt_pkg::*;
#(
    parameter int WI  = 10,
    parameter int WF  = 10,
    parameter int WL  = WI + WF,
    parameter int WIO = 10,
    parameter int WFO = 10
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          CE,
    input  logic          start,
    input  logic [WL-1:0] din,
    output logic          busy,
    output logic          valid,
    output logic [WL-1:0] dout,
    output logic          ovf
);

    if ((WI + WF != WL) || (WIO + WFO != WL)) begin : g_bad_cfg
        $error("fp_sisqrt_inv: word-length parameters are inconsistent");
    end

    localparam int            DW    = 2 * WL;
    localparam int            QW    = WL - 1;
    localparam int            RW    = DW + QW;
    localparam int            CW    = cnt_w(WL);
    localparam logic [RW-1:0] N_VAL = RW'(1) << n_exp(WF, WFO);
    localparam logic [WL-1:0] SAT   = WL'(sat_val(WL));

    state_t        state_q, state_d;
    logic [WL-1:0] din_q, din_d;
    logic [DW-1:0] s_q, s_d;
    logic [WL-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;

    logic [WL-1:0] mag;
    logic [RW-1:0] s_scaled;
    logic          div_load, div_step, div_done;
    logic [QW-1:0] div_q;

    // Unsigned view of |din|: the most-negative code negates to itself,
    // which read unsigned is exactly 2^(WL-1).
    assign mag      = din_q[WL-1] ? (~din_q + 1'b1) : din_q;
    assign s_scaled = {{QW{1'b0}}, s_q} << (WL - 1);

    fp_udiv_restoring #(
        .DW (DW),
        .QW (QW),
        .CW (CW)
    ) u_div (
        .clk    (CLK),
        .rst_n  (nRST),
        .ce     (CE),
        .load   (div_load),
        .step   (div_step),
        .num    (N_VAL),
        .den    (s_q),
        .q_next (div_q),
        .done   (div_done)
    );

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        s_d      = s_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    din_d   = din;
                    busy_d  = 1'b1;
                    state_d = SQR;
                end
            end
            SQR: begin
                s_d     = {{WL{1'b0}}, mag} * {{WL{1'b0}}, mag};
                state_d = CHK;
            end
            CHK: begin
                // Quotient would need more than WL-1 bits (or S=0): saturate.
                if (s_scaled <= N_VAL) begin
                    dout_d  = SAT;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    div_load = 1'b1;
                    state_d  = DIV;
                end
            end
            DIV: begin
                div_step = 1'b1;
                if (div_done) begin
                    dout_d  = {1'b0, div_q};
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            din_q   <= '0;
            s_q     <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (CE) begin
            state_q <= state_d;
            din_q   <= din_d;
            s_q     <= s_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign dout  = dout_q;
    assign ovf   = ovf_q;

endmodule : fp_sisqrt_inv

`default_nettype wire

// File: tb/tb_fp_sisqrt_inv.sv
// ============================================================================
// Module      : tb_fp_sisqrt_inv
// Description : Directed self-checking bench for fp_sisqrt_inv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_sisqrt_inv;

    localparam int WL = 20;

    logic          CLK   = 1'b0;
    logic          nRST  = 1'b0;
    logic          CE    = 1'b1;
    logic          start = 1'b0;
    logic [WL-1:0] din   = '0;
    wire           busy;
    wire           valid;
    wire           ovf;
    wire  [WL-1:0] dout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    fp_sisqrt_inv dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .CE    (CE),
        .start (start),
        .din   (din),
        .busy  (busy),
        .valid (valid),
        .dout  (dout),
        .ovf   (ovf)
    );

    // Present an operand; returns #1 after the edge that accepts it.
    task automatic launch(input logic [WL-1:0] d);
        @(negedge CLK);
        din   = d;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until valid is seen (#1 after an edge); -1 on timeout.
    task automatic wait_valid(input int limit, output int edges);
        int n;
        n = 0;
        while (n < limit) begin
            @(posedge CLK);
            #1;
            n++;
            if (valid === 1'b1) break;
        end
        edges = (valid === 1'b1) ? n : -1;
    endtask

    task automatic test_reset;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf); end
        vectors++; if (dout !== 20'd0) begin miscompares++; $display("FAIL reset_dout got %0d want 0", dout); end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_unity;
        int e;
        launch(20'd1024);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL unity_busy got %b want 1", busy); end
        wait_valid(60, e);
        vectors++; if (e !== 22) begin miscompares++; $display("FAIL unity_latency got %0d want 22", e); end
        vectors++; if (dout !== 20'd1024) begin miscompares++; $display("FAIL unity_dout got %0d want 1024", dout); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL unity_ovf got %b want 0", ovf); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL unity_busy_end got %b want 0", busy); end
        @(posedge CLK); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL unity_strobe got %b want 0", valid); end
    endtask

    task automatic test_back_to_back;
        int e;
        launch(20'd2048);
        wait_valid(60, e);
        vectors++; if (dout !== 20'd256) begin miscompares++; $display("FAIL b2b_first_dout got %0d want 256", dout); end
        // Re-assert start while valid is high.
        din   = 20'hFF800;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_valid(60, e);
        vectors++; if (e + 1 !== 23) begin miscompares++; $display("FAIL b2b_spacing got %0d want 23", e + 1); end
        vectors++; if (dout !== 20'd256) begin miscompares++; $display("FAIL b2b_second_dout got %0d want 256", dout); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_second_ovf got %b want 0", ovf); end
    endtask

    task automatic test_values;
        int e;
        launch(20'd1536);
        wait_valid(60, e);
        vectors++; if (dout !== 20'd455) begin miscompares++; $display("FAIL val_1p5 got %0d want 455", dout); end
        launch(20'd512);
        wait_valid(60, e);
        vectors++; if (dout !== 20'd4096) begin miscompares++; $display("FAIL val_0p5 got %0d want 4096", dout); end
    endtask

    task automatic test_saturation;
        int e;
        launch(20'd0);
        wait_valid(60, e);
        vectors++; if (e !== 3) begin miscompares++; $display("FAIL sat0_latency got %0d want 3", e); end
        vectors++; if (dout !== 20'h7FFFF) begin miscompares++; $display("FAIL sat0_dout got %h want 7ffff", dout); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat0_ovf got %b want 1", ovf); end
        launch(20'd45);
        wait_valid(60, e);
        vectors++; if (dout !== 20'h7FFFF) begin miscompares++; $display("FAIL sat45_dout got %h want 7ffff", dout); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat45_ovf got %b want 1", ovf); end
        launch(20'd46);
        wait_valid(60, e);
        // floor(2^30 / 2116) = 507439
        vectors++; if (dout !== 20'd507439) begin miscompares++; $display("FAIL sat46_dout got %0d want 507439", dout); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sat46_ovf got %b want 0", ovf); end
        vectors++; if (e !== 22) begin miscompares++; $display("FAIL sat46_latency got %0d want 22", e); end
    endtask

    task automatic test_extremes;
        int e;
        launch(20'h7FFFF);
        wait_valid(60, e);
        vectors++; if (dout !== 20'd0) begin miscompares++; $display("FAIL max_dout got %0d want 0", dout); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL max_ovf got %b want 0", ovf); end
        launch(20'd1024);
        wait_valid(60, e);
        launch(20'h80000);
        wait_valid(60, e);
        vectors++; if (dout !== 20'd0) begin miscompares++; $display("FAIL minneg_dout got %0d want 0", dout); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL minneg_ovf got %b want 0", ovf); end
    endtask

    task automatic test_start_while_busy;
        int e;
        int extra;
        launch(20'd1024);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        din   = 20'd2048;
        start = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_mid got %b want 1", busy); end
        wait_valid(60, e);
        vectors++; if (e + 10 !== 22) begin miscompares++; $display("FAIL busy_latency got %0d want 22", e + 10); end
        vectors++; if (dout !== 20'd1024) begin miscompares++; $display("FAIL busy_dout got %0d want 1024", dout); end
        extra = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (valid === 1'b1) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL busy_extra_valid got %0d want 0", extra); end
    endtask

    task automatic test_ce_stall;
        int e;
        launch(20'd1536);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        CE = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ce_busy_hold got %b want 1", busy); end
        @(negedge CLK);
        CE = 1'b1;
        wait_valid(60, e);
        vectors++; if (e + 15 !== 27) begin miscompares++; $display("FAIL ce_latency got %0d want 27", e + 15); end
        vectors++; if (dout !== 20'd455) begin miscompares++; $display("FAIL ce_dout got %0d want 455", dout); end
        // Freeze right on the strobe: valid must persist.
        CE = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL ce_valid_hold got %b want 1", valid); end
        @(negedge CLK);
        CE = 1'b1;
        @(posedge CLK); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ce_valid_drop got %b want 0", valid); end
    endtask

    task automatic test_reset_abort;
        int e;
        int extra;
        launch(20'd1024);
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
        vectors++; if (dout !== 20'd0) begin miscompares++; $display("FAIL abort_dout got %0d want 0", dout); end
        vectors++; if ({valid, ovf} !== 2'b00) begin miscompares++; $display("FAIL abort_flags got %b want 00", {valid, ovf}); end
        @(negedge CLK);
        nRST = 1'b1;
        extra = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (valid === 1'b1) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL abort_valid got %0d want 0", extra); end
        launch(20'd512);
        wait_valid(60, e);
        vectors++; if (e !== 22) begin miscompares++; $display("FAIL abort_next_latency got %0d want 22", e); end
        vectors++; if (dout !== 20'd4096) begin miscompares++; $display("FAIL abort_next_dout got %0d want 4096", dout); end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_back_to_back();
        test_values();
        test_saturation();
        test_extremes();
        test_start_while_busy();
        test_ce_stall();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fp_sisqrt_inv

`default_nettype wire
